// File: rtl/led_pattern_gen_if.sv
// LED pattern generator control/status bundle.
// master drives mode/pause; slave (the generator) drives led/tick/mode_q.
interface led_pattern_gen_if #(
    parameter int LED_W = 16
);
    logic [1:0]       mode;
    logic             pause;
    logic [LED_W-1:0] led;
    logic             tick;
    logic [1:0]       mode_q;

    modport master (
        output mode,
        output pause,
        input  led,
        input  tick,
        input  mode_q
    );

    modport slave (
        input  mode,
        input  pause,
        output led,
        output tick,
        output mode_q
    );
endinterface

// File: rtl/led_pattern_gen.sv
// Four-pattern LED animator stepped by a clock-enable divider.
// Optional LED_PATTERN_SYNC_EN: 2-flop synchronisers on mode and pause.
module led_pattern_gen #(
    parameter int LED_W    = 16,
    parameter int TICK_DIV = 8388608
) (
    input  logic              clk,
    input  logic              rst,
    led_pattern_gen_if.slave  bus
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]    LAST = CW'(TICK_DIV - 1);
    localparam logic [LED_W-1:0] MSB  = {1'b1, {(LED_W-1){1'b0}}};
    localparam logic [LED_W-1:0] LSB  = {{(LED_W-1){1'b0}}, 1'b1};
    localparam logic [LED_W-1:0] ONES = {LED_W{1'b1}};

    typedef enum logic {
        DIR_R = 1'b0,
        DIR_L = 1'b1
    } dir_t;

    logic [1:0] w_mode;
    logic       w_pause;

`ifdef LED_PATTERN_SYNC_EN
    logic [1:0] r_mode_s1;
    logic [1:0] r_mode_s2;
    logic       r_pause_s1;
    logic       r_pause_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_s1  <= 2'b00;
            r_mode_s2  <= 2'b00;
            r_pause_s1 <= 1'b0;
            r_pause_s2 <= 1'b0;
        end else begin
            r_mode_s1  <= bus.mode;
            r_mode_s2  <= r_mode_s1;
            r_pause_s1 <= bus.pause;
            r_pause_s2 <= r_pause_s1;
        end
    end

    assign w_mode  = r_mode_s2;
    assign w_pause = r_pause_s2;
`else
    assign w_mode  = bus.mode;
    assign w_pause = bus.pause;
`endif

    logic [CW-1:0]    r_cnt;
    logic [LED_W-1:0] r_led;
    logic [1:0]       r_mode_q;
    logic             r_tick;
    dir_t             r_dir;

    logic             w_last;
    logic             w_step;
    logic [LED_W-1:0] w_shr;
    logic [LED_W-1:0] w_shl;
    logic [LED_W-1:0] w_next_led;
    logic [1:0]       w_next_mode;
    dir_t             w_next_dir;

    assign w_last = (r_cnt == LAST);
    assign w_step = w_last & ~w_pause;
    assign w_shr  = r_led >> 1;
    assign w_shl  = r_led << 1;

    // A mode change consumes the step as a reload, never as an advance.
    always_comb begin
        w_next_led  = r_led;
        w_next_mode = r_mode_q;
        w_next_dir  = r_dir;
        if (w_mode != r_mode_q) begin
            w_next_mode = w_mode;
            w_next_dir  = DIR_R;
            w_next_led  = (w_mode == 2'b01) ? LSB : MSB;
        end else begin
            case (r_mode_q)
                2'b00: w_next_led = (r_led == LSB) ? MSB : w_shr;
                2'b01: w_next_led = (r_led == MSB) ? LSB : w_shl;
                2'b10: begin
                    if (r_dir == DIR_R) begin
                        w_next_led = w_shr;
                        if (w_shr == LSB)
                            w_next_dir = DIR_L;
                    end else begin
                        w_next_led = w_shl;
                        if (w_shl == MSB)
                            w_next_dir = DIR_R;
                    end
                end
                default: w_next_led = (r_led == ONES) ? MSB
                                    : {1'b1, r_led[LED_W-1:1]};
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_led    <= MSB;
            r_mode_q <= 2'b00;
            r_tick   <= 1'b0;
            r_dir    <= DIR_R;
        end else begin
            r_tick <= w_step;
            if (!w_pause)
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (w_step) begin
                r_led    <= w_next_led;
                r_mode_q <= w_next_mode;
                r_dir    <= w_next_dir;
            end
        end
    end

    assign bus.led    = r_led;
    assign bus.tick   = r_tick;
    assign bus.mode_q = r_mode_q;
endmodule
